// File: rtl/uart_frame_pkg.sv
// Shared types and constants for the framed UART register-write path.
package uart_frame_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_LEN,
        ST_DATA,
        ST_CSUM,
        ST_COMMIT,
        ST_RESP
    } state_e;

    localparam logic [2:0] ERR_LEN     = 3'd1;
    localparam logic [2:0] ERR_RANGE   = 3'd2;
    localparam logic [2:0] ERR_CSUM    = 3'd3;
    localparam logic [2:0] ERR_TIMEOUT = 3'd4;

    localparam logic [7:0] DEF_HEADER = 8'hA5;
    localparam logic [7:0] DEF_ACK    = 8'h06;
    localparam logic [7:0] DEF_NAK    = 8'h15;

endpackage

// File: rtl/uart_frame_regs_if.sv
// Byte-stream handshake between the UART rx/tx pair and the frame parser.
interface uart_frame_regs_if;
    logic [7:0] rx_data;
    logic       rx_vld;
    logic [7:0] tx_data;
    logic       tx_vld;
    logic       tx_rdy;

    modport master (output rx_data, output rx_vld, output tx_rdy,
                    input  tx_data, input  tx_vld);
    modport slave  (input  rx_data, input  rx_vld, input  tx_rdy,
                    output tx_data, output tx_vld);
endinterface

// File: rtl/frame_timeout_cnt.sv
// Inter-byte idle timer: down-counter reloaded on clear, expires after
// TIMEOUT_CYC consecutive enabled, uncleared cycles.
module frame_timeout_cnt #(
    parameter int unsigned TIMEOUT_CYC = 50_000
) (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);
    localparam int unsigned CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CW-1:0] LOAD = CW'(TIMEOUT_CYC - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = LOAD;
        end else if (en_i && cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) cnt_q <= LOAD;
        else         cnt_q <= cnt_d;
    end

    assign expire_o = en_i && !clr_i && (cnt_q == '0);

endmodule

// File: rtl/uart_frame_regs.sv
// Parses HEADER/ADDR/LEN/DATA/CSUM write frames into a byte register bank,
// committing only fully validated frames, and answers with ACK/NAK.
//
// state  | meaning
// IDLE   | hunting for HEADER, other bytes dropped
// ADDR   | waiting for start register address
// LEN    | waiting for byte count; length/range checked here
// DATA   | collecting payload into the frame buffer
// CSUM   | comparing received checksum with running sum
// COMMIT | copying buffer into the bank, one byte per cycle
// RESP   | presenting ACK/NAK until the transmitter takes it
module uart_frame_regs
    import uart_frame_pkg::*;
#(
    parameter int unsigned NUM_REGS    = 8,
    parameter int unsigned MAX_LEN     = 8,
    parameter logic [7:0]  HEADER      = DEF_HEADER,
    parameter logic [7:0]  ACK_BYTE    = DEF_ACK,
    parameter logic [7:0]  NAK_BYTE    = DEF_NAK,
    parameter int unsigned TIMEOUT_CYC = 50_000,
    parameter bit          ACK_EN      = 1'b1
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    uart_frame_regs_if.slave      uart,
    output logic [NUM_REGS*8-1:0] reg_data,
    output logic                  frame_ok,
    output logic                  frame_err,
    output logic [2:0]            err_code,
    output logic                  busy
);
    localparam int unsigned LW = $clog2(MAX_LEN + 1);

    state_e                state_q, state_d;
    logic [7:0]            addr_q, addr_d;
    logic [7:0]            sum_q, sum_d;
    logic [7:0]            resp_q, resp_d;
    logic [LW-1:0]         len_q, len_d;
    logic [LW-1:0]         idx_q, idx_d;
    logic [MAX_LEN*8-1:0]  buf_q, buf_d;
    logic [NUM_REGS*8-1:0] regs_q, regs_d;
    logic [2:0]            err_q, err_d;
    logic                  ok_q, ok_d;
    logic                  in_frame, tmo_expire, err_exit;
    logic [8:0]            end_addr;

    assign in_frame = state_q inside {ST_ADDR, ST_LEN, ST_DATA, ST_CSUM};
    // Nine bits so a high address plus length cannot wrap past the range check.
    assign end_addr = {1'b0, addr_q} + {1'b0, uart.rx_data};

    frame_timeout_cnt #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_tmo (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .clr_i    (uart.rx_vld || !in_frame),
        .en_i     (in_frame),
        .expire_o (tmo_expire)
    );

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        sum_d    = sum_q;
        resp_d   = resp_q;
        len_d    = len_q;
        idx_d    = idx_q;
        buf_d    = buf_q;
        regs_d   = regs_q;
        err_d    = err_q;
        ok_d     = 1'b0;
        err_exit = 1'b0;
        unique case (state_q)
            ST_IDLE: if (uart.rx_vld && uart.rx_data == HEADER) state_d = ST_ADDR;
            ST_ADDR: if (uart.rx_vld) begin
                addr_d  = uart.rx_data;
                sum_d   = uart.rx_data;
                state_d = ST_LEN;
            end
            ST_LEN: if (uart.rx_vld) begin
                sum_d = sum_q + uart.rx_data;
                if (uart.rx_data == 8'd0 || uart.rx_data > 8'(MAX_LEN)) begin
                    err_d    = ERR_LEN;
                    err_exit = 1'b1;
                end else if (end_addr > 9'(NUM_REGS)) begin
                    err_d    = ERR_RANGE;
                    err_exit = 1'b1;
                end else begin
                    len_d   = uart.rx_data[LW-1:0];
                    idx_d   = '0;
                    state_d = ST_DATA;
                end
            end
            ST_DATA: if (uart.rx_vld) begin
                buf_d[int'(idx_q)*8 +: 8] = uart.rx_data;
                sum_d = sum_q + uart.rx_data;
                idx_d = idx_q + LW'(1);
                if (idx_q == len_q - LW'(1)) state_d = ST_CSUM;
            end
            ST_CSUM: if (uart.rx_vld) begin
                if (uart.rx_data == sum_q) begin
                    idx_d   = '0;
                    state_d = ST_COMMIT;
                end else begin
                    err_d    = ERR_CSUM;
                    err_exit = 1'b1;
                end
            end
            ST_COMMIT: begin
                regs_d[(int'(addr_q) + int'(idx_q))*8 +: 8] = buf_q[int'(idx_q)*8 +: 8];
                idx_d = idx_q + LW'(1);
                if (idx_q == len_q - LW'(1)) begin
                    ok_d    = 1'b1;
                    state_d = ACK_EN ? ST_RESP : ST_IDLE;
                    if (ACK_EN) resp_d = ACK_BYTE;
                end
            end
            ST_RESP: if (uart.tx_rdy) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (tmo_expire) begin
            err_d    = ERR_TIMEOUT;
            err_exit = 1'b1;
        end
        if (err_exit) begin
            state_d = ACK_EN ? ST_RESP : ST_IDLE;
            if (ACK_EN) resp_d = NAK_BYTE;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            sum_q   <= '0;
            resp_q  <= '0;
            len_q   <= '0;
            idx_q   <= '0;
            buf_q   <= '0;
            regs_q  <= '0;
            err_q   <= '0;
            ok_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            sum_q   <= sum_d;
            resp_q  <= resp_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            buf_q   <= buf_d;
            regs_q  <= regs_d;
            err_q   <= err_d;
            ok_q    <= ok_d;
        end
    end

    assign reg_data     = regs_q;
    assign frame_ok     = ok_q;
    assign frame_err    = err_exit;
    assign err_code     = err_q;
    assign busy         = (state_q != ST_IDLE);
    assign uart.tx_vld  = (state_q == ST_RESP);
    assign uart.tx_data = resp_q;

endmodule

// File: tb/tb_uart_frame_regs.sv
// Directed bench for uart_frame_regs: response bytes go through a queue,
// register contents against a bench-side model of the bank.
module tb_uart_frame_regs;
    import uart_frame_pkg::*;

    localparam int TMO = 50_000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_frame_regs_if u_if ();
    uart_frame_regs_if u_if2 ();

    logic [63:0] reg_data, reg_data2;
    logic        frame_ok, frame_err, busy, frame_ok2, frame_err2, busy2;
    logic [2:0]  err_code, err_code2;

    uart_frame_regs #(.NUM_REGS(8), .MAX_LEN(8), .TIMEOUT_CYC(TMO), .ACK_EN(1'b1)) u_dut (
        .sys_clk(clk), .sys_rst(rst), .uart(u_if), .reg_data(reg_data),
        .frame_ok(frame_ok), .frame_err(frame_err), .err_code(err_code), .busy(busy));

    uart_frame_regs #(.NUM_REGS(8), .MAX_LEN(8), .TIMEOUT_CYC(TMO), .ACK_EN(1'b0)) u_dut2 (
        .sys_clk(clk), .sys_rst(rst), .uart(u_if2), .reg_data(reg_data2),
        .frame_ok(frame_ok2), .frame_err(frame_err2), .err_code(err_code2), .busy(busy2));

    int          checks = 0;
    int          failures = 0;
    logic [7:0]  resp_q[$];
    logic [7:0]  exp_regs[8];
    logic        last_err;
    logic        tx2_seen = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] pack_regs();
        logic [63:0] p;
        for (int k = 0; k < 8; k++) p[8*k +: 8] = exp_regs[k];
        return p;
    endfunction

    // Response scoreboard: every handshake must match the oldest expected byte.
    always @(negedge clk) begin
        logic [7:0] e;
        if (!rst && u_if.tx_vld === 1'b1 && u_if.tx_rdy === 1'b1) begin
            e = 8'hxx;
            if (resp_q.size() > 0) e = resp_q.pop_front();
            chk("resp_byte", u_if.tx_data, e);
        end
        if (u_if2.tx_vld === 1'b1) tx2_seen = 1'b1;
    end

    task automatic send_byte(input logic [7:0] b);
        u_if.rx_data = b;
        u_if.rx_vld  = 1'b1;
        @(negedge clk);
        last_err = frame_err;
        @(posedge clk); #1;
        u_if.rx_vld = 1'b0;
    endtask

    task automatic send_byte2(input logic [7:0] b);
        u_if2.rx_data = b;
        u_if2.rx_vld  = 1'b1;
        @(posedge clk); #1;
        u_if2.rx_vld = 1'b0;
    endtask

    task automatic scan(input int n, output int okf, output int okc, output int errf, output int errc);
        okf = -1; okc = 0; errf = -1; errc = 0;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            if (frame_ok === 1'b1) begin okc++; if (okf < 0) okf = c; end
            if (frame_err === 1'b1) begin errc++; if (errf < 0) errf = c; end
            @(posedge clk); #1;
        end
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        while (busy !== 1'b0 && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, "_idle_reached"}, 64'(n < budget), 64'd1);
    endtask

    task automatic good_frame(input string tag, input logic [7:0] addr, input int len, input logic [63:0] d);
        logic [7:0] s;
        int okf, okc, errf, errc;
        resp_q.push_back(DEF_ACK);
        s = addr + 8'(len);
        send_byte(DEF_HEADER);
        send_byte(addr);
        send_byte(8'(len));
        for (int k = 0; k < len; k++) begin
            send_byte(d[8*k +: 8]);
            s = s + d[8*k +: 8];
        end
        send_byte(s);
        scan(len + 2, okf, okc, errf, errc);
        chk({tag, "_ok_offset"}, 64'(okf), 64'(len));
        chk({tag, "_ok_pulses"}, 64'(okc), 64'd1);
        chk({tag, "_no_err"}, 64'(errc), 64'd0);
        for (int k = 0; k < len; k++) exp_regs[int'(addr) + k] = d[8*k +: 8];
        chk({tag, "_regs"}, reg_data, pack_regs());
    endtask

    // Sends the given bytes; the last one must trigger the error exit.
    task automatic bad_frame(input string tag, input int n, input logic [63:0] b, input logic [2:0] code);
        resp_q.push_back(DEF_NAK);
        for (int k = 0; k < n; k++) send_byte(b[8*k +: 8]);
        chk({tag, "_err_pulse"}, 64'(last_err), 64'd1);
        @(negedge clk);
        chk({tag, "_err_code"}, 64'(err_code), 64'(code));
        chk({tag, "_err_single"}, 64'(frame_err), 64'd0);
        @(posedge clk); #1;
        wait_idle(tag, 20);
        chk({tag, "_regs_kept"}, reg_data, pack_regs());
    endtask

    initial begin
        int okf, okc, errf, errc, stable;
        logic [63:0] part;
        for (int k = 0; k < 8; k++) exp_regs[k] = 8'h00;
        u_if.rx_data = 8'h00; u_if.rx_vld = 1'b0; u_if.tx_rdy = 1'b1;
        u_if2.rx_data = 8'h00; u_if2.rx_vld = 1'b0; u_if2.tx_rdy = 1'b1;

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_reg_data", reg_data, 64'd0);
        chk("rst_tx_vld", 64'(u_if.tx_vld), 64'd0);
        chk("rst_tx_data", 64'(u_if.tx_data), 64'd0);
        chk("rst_frame_ok", 64'(frame_ok), 64'd0);
        chk("rst_frame_err", 64'(frame_err), 64'd0);
        chk("rst_err_code", 64'(err_code), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        @(posedge clk); #1;

        // Reset after the payload, before the checksum.
        send_byte(8'hA5); send_byte(8'h00); send_byte(8'h02); send_byte(8'h33); send_byte(8'h44);
        chk("midrst_busy_before", 64'(busy), 64'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        send_byte(8'h79);
        repeat (4) @(posedge clk);
        #1;
        chk("midrst_regs", reg_data, 64'd0);
        chk("midrst_tx_vld", 64'(u_if.tx_vld), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);

        good_frame("good1", 8'h02, 2, 64'h2211);
        wait_idle("good1", 20);

        bad_frame("csum", 6, 64'h38_22_11_02_02_A5, ERR_CSUM);
        bad_frame("range", 3, 64'h02_07_A5, ERR_RANGE);
        bad_frame("len0", 3, 64'h00_00_A5, ERR_LEN);
        bad_frame("len9", 3, 64'h09_00_A5, ERR_LEN);

        // Ends exactly at the last register; one payload byte equals HEADER.
        good_frame("good_edge", 8'h05, 3, 64'hA5_BB_AA);
        wait_idle("good_edge", 20);

        send_byte(8'h00); send_byte(8'h5A); send_byte(8'h06);
        chk("garbage_not_busy", 64'(busy), 64'd0);
        good_frame("good_after_garbage", 8'h00, 1, 64'h7E);
        wait_idle("good_after_garbage", 20);

        resp_q.push_back(DEF_NAK);
        send_byte(8'hA5); send_byte(8'h01);
        scan(TMO + 3, okf, okc, errf, errc);
        chk("tmo_err_offset", 64'(errf), 64'(TMO - 1));
        chk("tmo_err_pulses", 64'(errc), 64'd1);
        chk("tmo_no_ok", 64'(okc), 64'd0);
        chk("tmo_err_code", 64'(err_code), 64'(ERR_TIMEOUT));
        wait_idle("tmo", 20);
        chk("tmo_regs_kept", reg_data, pack_regs());

        // Back-pressure in RESP with rx traffic that must be dropped.
        u_if.tx_rdy = 1'b0;
        good_frame("bp", 8'h01, 1, 64'h5C);
        stable = 0;
        for (int i = 0; i < 100; i++) begin
            u_if.rx_vld  = (i % 3 == 0);
            u_if.rx_data = (i % 2 == 0) ? 8'hA5 : 8'h02;
            @(negedge clk);
            if (u_if.tx_vld === 1'b1 && u_if.tx_data === DEF_ACK && busy === 1'b1) stable++;
            @(posedge clk); #1;
        end
        u_if.rx_vld = 1'b0;
        chk("bp_stable_cycles", 64'(stable), 64'd100);
        u_if.tx_rdy = 1'b1;
        wait_idle("bp", 20);
        repeat (3) @(posedge clk);
        #1;
        chk("bp_stays_idle", 64'(busy), 64'd0);
        chk("bp_regs", reg_data, pack_regs());

        // No-response variant: full-bank write, watched one cycle at a time.
        send_byte2(8'hA5); send_byte2(8'h00); send_byte2(8'h08);
        for (int k = 1; k <= 8; k++) send_byte2(8'(k));
        send_byte2(8'h2C);
        okf = -1; okc = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            part = 64'd0;
            for (int k = 0; k < 8; k++) if (k < c) part[8*k +: 8] = 8'(k + 1);
            chk($sformatf("noack_regs_c%0d", c), reg_data2, part);
            if (frame_ok2 === 1'b1) begin okc++; if (okf < 0) okf = c; end
            @(posedge clk); #1;
        end
        chk("noack_ok_offset", 64'(okf), 64'd8);
        chk("noack_ok_pulses", 64'(okc), 64'd1);
        chk("noack_no_tx_vld", 64'(tx2_seen), 64'd0);
        chk("noack_idle", 64'(busy2), 64'd0);

        chk("resp_queue_drained", 64'(resp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_frame_regs.md
Name: uart_frame_regs

Overview:
Parametrised successor of the display-data path in the top level. It parses framed multi-byte write commands from the MCU UART byte stream into a register bank of NUM_REGS bytes. The bank drives the seg display, LEDs and other consumers. The block validates header, length, address range and checksum, commits a frame atomically only when it is good, and returns an ACK/NAK byte to the UART transmitter. It sits between the uart receiver/transmitter and the display/control logic in Top.

Parameters:
NUM_REGS, 8, number of 8-bit registers in the bank (2..64)
MAX_LEN, 8, maximum data bytes per frame (1..NUM_REGS)
HEADER, 8'hA5, frame start byte
ACK_BYTE, 8'h06, response sent for a good frame
NAK_BYTE, 8'h15, response sent for a rejected frame
TIMEOUT_CYC, 50_000, maximum idle cycles between bytes inside a frame (1 ms at 50 MHz)
ACK_EN, 1, 1 = send the response byte; 0 = skip the response state

Ports:
sys_clk  in  1  system clock
sys_rst  in  1  synchronous, active-high reset
rx_data  in  8  received byte
rx_vld  in  1  one-cycle strobe, rx_data valid
tx_data  out  8  response byte
tx_vld  out  1  response valid; held until tx_rdy
tx_rdy  in  1  transmitter accepts tx_data when tx_vld && tx_rdy
reg_data  out  NUM_REGS*8  register bank, reg 0 at bits [7:0]
frame_ok  out  1  one-cycle pulse when a frame is committed
frame_err  out  1  one-cycle pulse when a frame is rejected
err_code  out  3  code of the last error, held: 1 = bad length, 2 = range, 3 = checksum, 4 = timeout
busy  out  1  high outside IDLE/HDR-hunt; rx bytes are ignored in COMMIT and RESP

Behaviour:
- Frame format: HEADER, ADDR, LEN, LEN data bytes, CSUM. CSUM is the 8-bit modulo sum of ADDR, LEN and all data bytes.
- Reset values: reg_data = 0, tx_vld = 0, tx_data = 0, frame_ok = 0, frame_err = 0, err_code = 0, busy = 0, state = IDLE. Reset mid-frame discards the buffer and changes no register.
- States: IDLE, ADDR, LEN, DATA, CSUM, COMMIT, RESP.
- IDLE: on rx_vld with rx_data == HEADER go to ADDR. Any other byte is ignored.
- ADDR: latch addr, go to LEN.
- LEN, bad length: if LEN == 0 or LEN > MAX_LEN, err_code = 1 and error exit.
- LEN, range: else if addr + LEN > NUM_REGS (compare at 9-bit width, no wrap), err_code = 2 and error exit.
- LEN, accepted: else latch len, clear the byte index, go to DATA.
- DATA: store each byte in buffer[idx] and increment idx. After the byte where idx == len-1, go to CSUM.
- CSUM: the running sum is accumulated from ADDR onward. On a match go to COMMIT; on a mismatch err_code = 3 and error exit.
- Timeout: in ADDR, LEN, DATA and CSUM a counter is cleared on every rx_vld. When it reaches TIMEOUT_CYC-1 without a byte, err_code = 4 and error exit.
- Error exit: frame_err pulses for one cycle in the exit cycle. Go to RESP with NAK_BYTE, or to IDLE if ACK_EN = 0. Registers are untouched.
- COMMIT: write one register per cycle, reg[addr+k] <= buffer[k] for k = 0..len-1. If the CSUM byte is accepted in cycle N, the write of byte k happens in cycle N+1+k and is visible on reg_data in cycle N+2+k.
- Commit completion: frame_ok pulses in cycle N+1+len, the same cycle the last write becomes visible. Then go to RESP with ACK_BYTE, or to IDLE if ACK_EN = 0.
- RESP: tx_vld = 1 with tx_data stable until tx_rdy. On handshake, tx_vld drops the next cycle and the state returns to IDLE. rx bytes arriving during COMMIT/RESP are dropped.
- Bytes not referenced by a committed frame keep their values indefinitely.
- A data byte equal to HEADER inside a frame is treated as data, not as a resync.

Decomposition:
- Package uart_frame_pkg holds the state encoding, the err_code constants (ERR_LEN, ERR_RANGE, ERR_CSUM, ERR_TIMEOUT) and the default HEADER/ACK/NAK bytes.
- One sub-module, frame_timeout_cnt: a parametrised counter with clear and expire outputs.
- The register bank and buffer stay inline.

Test Plan:
- Good frame: A5 02 02 11 22 37 -> reg2 = 11, reg3 = 22, others 0; frame_ok one pulse; tx_data = 06 with tx_vld held until tx_rdy.
- Bad checksum: A5 02 02 11 22 38 -> frame_err, err_code = 3, reg_data unchanged, tx_data = 15.
- Length and range errors: A5 07 02 … -> err_code = 2 after the LEN byte; A5 00 00 -> err_code = 1; A5 00 09 (MAX_LEN = 8) -> err_code = 1. NAK each time; the bench then sends a good frame, which is accepted.
- Timeout: A5 01, then stall 50_000 cycles -> frame_err at exactly TIMEOUT_CYC idle cycles, err_code = 4. Also inject 3 garbage bytes before a header -> ignored, and the frame parses.
- Reset and back-pressure: assert sys_rst after the DATA bytes -> regs stay 0, tx_vld = 0. Separately, hold tx_rdy = 0 for 100 cycles in RESP -> tx_vld and tx_data stable, rx bytes ignored.
- ACK_EN = 0, A5 00 08 with bytes 01..08 and checksum 2C -> all 8 regs written over 8 cycles, frame_ok pulses, tx_vld never rises.
